// File: rtl/rx_char_fifo_if.sv
// Stream bundle between the UART character recovery stage, the receive FIFO and the host reader.
// Latency: none; this file carries wires only.
// Backpressure: recovery side has no backpressure; host side uses a valid_o/ready_i handshake.
interface rx_char_fifo_if #(
  parameter int DATA_BITS = 8
);
  // Recovery-stage side: one-cycle strobes with the character
  logic [DATA_BITS-1:0] char_i;
  logic                 valid_i;
  logic                 frame_error_i;
  logic                 parity_error_i;

  // Host side: show-ahead head entry with a valid/ready handshake
  logic [DATA_BITS-1:0] data_o;
  logic                 frame_err_o;
  logic                 parity_err_o;
  logic                 valid_o;
  logic                 ready_i;

  // FIFO view
  modport slave (
    input  char_i, valid_i, frame_error_i, parity_error_i, ready_i,
    output data_o, frame_err_o, parity_err_o, valid_o
  );

  // Producer/consumer view (recovery stage plus host reader)
  modport master (
    output char_i, valid_i, frame_error_i, parity_error_i, ready_i,
    input  data_o, frame_err_o, parity_err_o, valid_o
  );
endinterface

// File: rtl/rx_char_fifo.sv
// Receive character FIFO: queues recovered characters with frame/parity tags and flags overrun.
// Latency: one cycle from push to valid_o; no bypass. Head outputs are registered and show-ahead.
// Backpressure: ready_i stalls the head; a push into a full FIFO without a pop is dropped and overrun_o is set.
module rx_char_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16,
  parameter int AF_LEVEL  = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  rx_char_fifo_if.slave              bus,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       almost_full_o,
  output logic                       overrun_o,
  input  logic                       overrun_clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // One stored slot: error tags kept alongside the character
  typedef struct packed {
    logic                 frame_err;
    logic                 parity_err;
    logic [DATA_BITS-1:0] chr;
  } entry_t;

  // Storage is deliberately not reset; occupancy is tracked by count_q
  entry_t mem [DEPTH];

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  entry_t        entry_in;
  entry_t        head_q;
  entry_t        head_nxt;
  logic          head_ld;
  logic          valid_q;
  logic          af_q;
  logic          ovr_q;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic          drop;

  // Handshake decode: any strobe from the recovery stage is a push, errored or not
  always_comb begin
    entry_in = '{frame_err: bus.frame_error_i, parity_err: bus.parity_error_i, chr: bus.char_i};
    push     = bus.valid_i | bus.frame_error_i | bus.parity_error_i;
    pop      = valid_q & bus.ready_i;
    full     = (count_q == CW'(DEPTH));
    // A pop in the same cycle frees the slot the push needs, so a full FIFO can still accept
    wr_en    = push & (~full | pop);
    drop     = push & full & ~pop;
  end

  // Next occupancy and next read pointer
  always_comb begin
    count_nxt  = count_q;
    rd_ptr_nxt = rd_ptr_q;
    if (pop) begin
      rd_ptr_nxt = rd_ptr_q + 1'b1;
    end
    unique case ({wr_en, pop})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Next head entry: the incoming character when it lands at the new head slot, else storage
  always_comb begin
    head_ld  = pop | ~valid_q;
    head_nxt = '0;
    if (count_nxt == '0) begin
      head_nxt = '0;
    end else if (wr_en && (wr_ptr_q == rd_ptr_nxt)) begin
      head_nxt = entry_in;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  // Storage write port
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= entry_in;
    end
  end

  // Pointers, occupancy, status flags and the registered head entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      af_q     <= 1'b0;
      ovr_q    <= 1'b0;
      head_q   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      rd_ptr_q <= rd_ptr_nxt;
      count_q  <= count_nxt;
      valid_q  <= (count_nxt != '0);
      af_q     <= (count_nxt >= CW'(AF_LEVEL));
      // A drop in the same cycle as a clear must still be reported
      ovr_q    <= drop | (ovr_q & ~overrun_clr_i);
      if (head_ld) begin
        head_q <= head_nxt;
      end
    end
  end

  // Output mapping
  always_comb begin
    bus.data_o       = head_q.chr;
    bus.frame_err_o  = head_q.frame_err;
    bus.parity_err_o = head_q.parity_err;
    bus.valid_o      = valid_q;
    count_o          = count_q;
    almost_full_o    = af_q;
    overrun_o        = ovr_q;
  end

endmodule

// File: tb/tb_rx_char_fifo.sv
// Bench for rx_char_fifo: directed vector table, hand-written corner sequences, random stream vs queue model.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: drives ready_i from tables and $urandom.
module tb_rx_char_fifo;
  localparam int DB    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ov_clr = 1'b0;
  logic [CW-1:0] count;
  logic          af;
  logic          ov;

  always #5 clk = ~clk;

  rx_char_fifo_if #(.DATA_BITS(DB)) bus ();

  rx_char_fifo #(.DATA_BITS(DB), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bus           (bus),
    .count_o       (count),
    .almost_full_o (af),
    .overrun_o     (ov),
    .overrun_clr_i (ov_clr)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a plain queue of {frame, parity, char} plus a sticky overrun bit
  logic [9:0] mq[$];
  bit         m_ov = 1'b0;

  typedef struct {
    bit       rdy, vld, fe, pe;
    bit [7:0] ch;
    bit       clr;
    bit       e_vld;
    bit [7:0] e_dat;
    bit       e_fe, e_pe;
    int       e_cnt;
    bit       e_af, e_ov;
  } vec_t;

  vec_t tbl[8];

  function automatic vec_t mk(bit rdy, bit vld, bit fe, bit pe, bit [7:0] ch, bit clr,
                              bit e_vld, bit [7:0] e_dat, bit e_fe, bit e_pe, int e_cnt,
                              bit e_af, bit e_ov);
    vec_t v;
    v.rdy = rdy; v.vld = vld; v.fe = fe; v.pe = pe; v.ch = ch; v.clr = clr;
    v.e_vld = e_vld; v.e_dat = e_dat; v.e_fe = e_fe; v.e_pe = e_pe;
    v.e_cnt = e_cnt; v.e_af = e_af; v.e_ov = e_ov;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the same rules, then settle after the edge
  task automatic drive(input bit rdy, input bit vld, input bit fe, input bit pe,
                       input bit [7:0] ch, input bit clr);
    bit push, pop, full;
    bus.ready_i        = rdy;
    bus.valid_i        = vld;
    bus.frame_error_i  = fe;
    bus.parity_error_i = pe;
    bus.char_i         = ch;
    ov_clr             = clr;
    push = vld | fe | pe;
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && rdy;
    if (pop) void'(mq.pop_front());
    if (push && (!full || pop)) mq.push_back({fe, pe, ch});
    if (clr) m_ov = 1'b0;
    if (push && full && !pop) m_ov = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i        = 1'b0;
    bus.frame_error_i  = 1'b0;
    bus.parity_error_i = 1'b0;
    bus.ready_i        = 1'b0;
    ov_clr             = 1'b0;
  endtask

  task automatic check_model(input string name);
    chk({name, "_valid"}, int'(bus.valid_o), int'(mq.size() != 0));
    chk({name, "_count"}, int'(count), mq.size());
    chk({name, "_af"}, int'(af), int'(mq.size() >= AF));
    chk({name, "_ov"}, int'(ov), int'(m_ov));
    if (mq.size() != 0) begin
      chk({name, "_data"}, int'(bus.data_o), int'(mq[0][7:0]));
      chk({name, "_fe"}, int'(bus.frame_err_o), int'(mq[0][9]));
      chk({name, "_pe"}, int'(bus.parity_err_o), int'(mq[0][8]));
    end
  endtask

  initial begin
    int accepted;
    int cyc;
    bus.char_i = '0; bus.valid_i = 1'b0; bus.frame_error_i = 1'b0;
    bus.parity_error_i = 1'b0; bus.ready_i = 1'b0;

    tbl[0] = mk(0, 1, 0, 0, 8'hA5, 0,  1, 8'hA5, 0, 0, 1, 0, 0);
    tbl[1] = mk(0, 0, 1, 0, 8'h3C, 0,  1, 8'hA5, 0, 0, 2, 0, 0);
    tbl[2] = mk(1, 0, 0, 0, 8'h00, 0,  1, 8'h3C, 1, 0, 1, 0, 0);
    tbl[3] = mk(0, 0, 0, 1, 8'h5A, 0,  1, 8'h3C, 1, 0, 2, 0, 0);
    tbl[4] = mk(1, 0, 0, 0, 8'h00, 0,  1, 8'h5A, 0, 1, 1, 0, 0);
    tbl[5] = mk(1, 0, 1, 1, 8'h11, 0,  1, 8'h11, 1, 1, 1, 0, 0);
    tbl[6] = mk(1, 0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 0, 0);
    tbl[7] = mk(1, 0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_valid", int'(bus.valid_o), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_af", int'(af), 0);
    chk("rst_ov", int'(ov), 0);
    chk("rst_data", int'(bus.data_o), 0);
    chk("rst_fe", int'(bus.frame_err_o), 0);
    chk("rst_pe", int'(bus.parity_err_o), 0);

    // Directed vector table
    foreach (tbl[i]) begin
      drive(tbl[i].rdy, tbl[i].vld, tbl[i].fe, tbl[i].pe, tbl[i].ch, tbl[i].clr);
      chk($sformatf("vec%0d_valid", i), int'(bus.valid_o), int'(tbl[i].e_vld));
      chk($sformatf("vec%0d_count", i), int'(count), tbl[i].e_cnt);
      chk($sformatf("vec%0d_af", i), int'(af), int'(tbl[i].e_af));
      chk($sformatf("vec%0d_ov", i), int'(ov), int'(tbl[i].e_ov));
      if (tbl[i].e_vld) begin
        chk($sformatf("vec%0d_data", i), int'(bus.data_o), int'(tbl[i].e_dat));
        chk($sformatf("vec%0d_fe", i), int'(bus.frame_err_o), int'(tbl[i].e_fe));
        chk($sformatf("vec%0d_pe", i), int'(bus.parity_err_o), int'(tbl[i].e_pe));
      end
    end

    // Fill to DEPTH with no reader; almost_full from count 12
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 0, 0, 8'(i), 0);
      chk($sformatf("fill%0d_count", i), int'(count), i + 1);
      chk($sformatf("fill%0d_af", i), int'(af), int'(i + 1 >= AF));
      chk($sformatf("fill%0d_head", i), int'(bus.data_o), 0);
    end
    drive(0, 1, 0, 0, 8'h55, 0);
    chk("ovr_count", int'(count), DEPTH);
    chk("ovr_flag", int'(ov), 1);
    chk("ovr_head", int'(bus.data_o), 0);
    // Drop coinciding with clear: set wins
    drive(0, 1, 0, 0, 8'h66, 1);
    chk("ovr_setwins", int'(ov), 1);
    drive(0, 0, 0, 0, 8'h00, 1);
    chk("ovr_clr", int'(ov), 0);

    // Full with simultaneous pop and push
    drive(1, 1, 0, 0, 8'h77, 0);
    chk("fullpp_count", int'(count), DEPTH);
    chk("fullpp_head", int'(bus.data_o), 1);
    chk("fullpp_ov", int'(ov), 0);
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("drain%0d", k), int'(bus.data_o), (k < DEPTH - 1) ? k + 1 : 8'h77);
      drive(1, 0, 0, 0, 8'h00, 0);
    end
    chk("drain_valid", int'(bus.valid_o), 0);
    chk("drain_count", int'(count), 0);

    // Mid-operation reset discards everything at once
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 8'(8'hC0 + i), 0);
    chk("prerst_count", int'(count), 5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(bus.valid_o), 0);
    chk("midrst_count", int'(count), 0);
    mq.delete();
    m_ov = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 1, 0, 0, 8'h81, 0);
    chk("postrst_head", int'(bus.data_o), 8'h81);
    chk("postrst_count", int'(count), 1);
    drive(1, 0, 0, 0, 8'h00, 0);
    check_model("postrst_pop");

    // Random stream against the queue model
    accepted = 0;
    cyc = 0;
    while (accepted < 40 && cyc < 2000) begin
      bit rdy, dop, fe, pe, clr;
      rdy = 1'($urandom_range(0, 1));
      dop = ($urandom_range(0, 1) == 1);
      fe  = dop && ($urandom_range(0, 5) == 0);
      pe  = dop && ($urandom_range(0, 5) == 0);
      clr = ($urandom_range(0, 15) == 0);
      if (dop && (mq.size() < DEPTH || (rdy && mq.size() != 0))) accepted++;
      drive(rdy, dop & ~fe & ~pe, fe, pe, 8'($urandom), clr);
      check_model($sformatf("rnd%0d", cyc));
      chk("rnd_cnt_le_depth", int'(int'(count) <= DEPTH), 1);
      cyc++;
    end
    chk("rnd_budget", int'(accepted >= 40), 1);
    cyc = 0;
    while (mq.size() != 0 && cyc < 40) begin
      drive(1, 0, 0, 0, 8'h00, 0);
      check_model($sformatf("rdrain%0d", cyc));
      cyc++;
    end
    chk("rnd_empty", int'(bus.valid_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
